// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder.
//   qdec_state_e : decoder FSM state encoding (ST_INIT, ST_TRACK)
//   PH0..PH3     : Gray-code phase values in "up" order
//   DIR_UP/DIR_DN: values driven on the U output
//   gray_next()  : phase that follows a given phase in the up direction
package qdec_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } qdec_state_e;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic [1:0] gray_next(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset (both flops clear to 0)
//   d     : asynchronous input
//   q     : synchronized output, two clk edges after d settles
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes phase inputs A/B, decodes Gray steps into a
// one-cycle enable pulse E with direction U, keeps a wrapping position count
// Pos, and flags double-bit (illegal) transitions on sticky Err.
//
// Optional build macro QDEC_FILTER_EN inserts a stability filter between the
// synchronizer and the compare stage: a new A/B pair is accepted only after
// FILT_CYC consecutive identical samples (FILT_CYC must be >= 2).
//
// Ports:
//   Clk    : system clock, rising edge
//   Rst    : asynchronous active-low reset
//   A, B   : phase inputs, asynchronous to Clk
//   ErrClr : synchronous clear of Err (a same-cycle illegal step wins)
//   E      : one-cycle step pulse
//   U      : direction of current/last step (1 = up, 0 = down)
//   Pos    : running position, wraps modulo 2^CNT_W
//   Err    : sticky illegal-transition flag
//   state  : FSM state, for observation only
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned FILT_CYC = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             A,
  input  logic             B,
  input  logic             ErrClr,
  output logic             E,
  output logic             U,
  output logic [CNT_W-1:0] Pos,
  output logic             Err,
  output qdec_state_e      state
);

  // Counter is sized for the longest (filtered) start-up wait in either build.
  localparam int unsigned INIT_W = $clog2(FILT_CYC + 4);

  // INIT must last until the compare-stage input reflects the real pins:
  // two synchronizer edges, plus the filter acceptance time when present.
`ifdef QDEC_FILTER_EN
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(2 + FILT_CYC);
`else
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(2);
`endif

  logic              a_s;
  logic              b_s;
  logic [1:0]        ab_s;
  logic [1:0]        ab_cmp;
  logic [1:0]        ab_q;
  logic [1:0]        diff;
  logic [INIT_W-1:0] init_cnt;
  qdec_state_e       state_q;
  qdec_state_e       state_d;
  logic              load_q;
  logic              step_valid;
  logic              step_dir;
  logic              illegal;

  sync_2ff u_sync_a (.clk(Clk), .rst_n(Rst), .d(A), .q(a_s));
  sync_2ff u_sync_b (.clk(Clk), .rst_n(Rst), .d(B), .q(b_s));

  assign ab_s = {a_s, b_s};

`ifdef QDEC_FILTER_EN
  localparam int unsigned FW = $clog2(FILT_CYC + 1);

  logic [1:0]    cand;
  logic [FW-1:0] fcnt;
  logic [1:0]    ab_f;

  // fcnt counts consecutive samples equal to cand; the FILT_CYC-th equal
  // sample promotes cand to ab_f, then fcnt saturates until cand changes.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cand <= 2'b00;
      fcnt <= '0;
      ab_f <= 2'b00;
    end else if (ab_s != cand) begin
      cand <= ab_s;
      fcnt <= FW'(1);
    end else if (fcnt != FW'(FILT_CYC)) begin
      fcnt <= fcnt + 1'b1;
      if (fcnt == FW'(FILT_CYC - 1)) begin
        ab_f <= cand;
      end
    end
  end

  assign ab_cmp = ab_f;
`else
  assign ab_cmp = ab_s;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT && init_cnt != INIT_LAST) begin
        init_cnt <= init_cnt + 1'b1;
      end
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && init_cnt == INIT_LAST) begin
      state_d = ST_TRACK;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    load_q     = 1'b0;
    step_valid = 1'b0;
    illegal    = 1'b0;
    diff       = ab_cmp ^ ab_q;
    step_dir   = (ab_cmp == gray_next(ab_q)) ? DIR_UP : DIR_DN;
    if (state_q == ST_INIT) begin
      // Seeding ab_q on exit means the first compare sees no change.
      load_q = (init_cnt == INIT_LAST);
    end else begin
      load_q     = 1'b1;
      step_valid = (diff == 2'b01) || (diff == 2'b10);
      illegal    = (diff == 2'b11);
    end
  end

  assign state = state_q;

  // ---------------- Datapath ----------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ab_q <= 2'b00;
      E    <= 1'b0;
      U    <= 1'b0;
      Pos  <= '0;
      Err  <= 1'b0;
    end else begin
      if (load_q) begin
        ab_q <= ab_cmp;
      end
      E <= step_valid;
      if (step_valid) begin
        U   <= step_dir;
        Pos <= (step_dir == DIR_UP) ? Pos + 1'b1 : Pos - 1'b1;
      end
      if (illegal) begin
        Err <= 1'b1;
      end else if (ErrClr) begin
        Err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder: reset behaviour, up/down stepping with
// wrap, illegal-step error handling, asynchronous mid-run reset and (when
// QDEC_FILTER_EN is defined) glitch rejection.
module tb_quad_decoder;
  import qdec_pkg::*;

`ifdef QDEC_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  // ---------------- clock / reset ----------------
  logic        Clk;
  logic        Rst;
  logic        A;
  logic        B;
  logic        ErrClr;
  logic        E;
  logic        U;
  logic [3:0]  Pos;
  logic        Err;
  qdec_state_e state;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  quad_decoder #(.CNT_W(4), .FILT_CYC(3)) dut (
    .Clk(Clk), .Rst(Rst), .A(A), .B(B), .ErrClr(ErrClr),
    .E(E), .U(U), .Pos(Pos), .Err(Err), .state(state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulses    = 0;
  logic [1:0] up_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      if (E === 1'b1) pulses++;
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    {A, B} = ab;
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    set_ab(ab);
    hold(2);
    Rst = 1'b1;
    hold(12);
    pulses = 0;
  endtask

  initial begin
    // 1) reset with A=B=1, release, no spurious step
    Rst = 1'b0; ErrClr = 1'b0; set_ab(2'b11);
    hold(3);
    check("rst_E",   E,   0);
    check("rst_U",   U,   0);
    check("rst_Pos", Pos, 0);
    check("rst_Err", Err, 0);
    check("rst_state", state, ST_INIT);
    Rst = 1'b1;
    pulses = 0;
    hold(12);
    check("init11_pulses", pulses, 0);
    check("init11_Pos",    Pos,    0);
    check("init11_Err",    Err,    0);
    check("init11_state",  state,  ST_TRACK);

    // 2) 20 up steps from 00, first-step latency checked edge by edge
    do_reset(2'b00);
    set_ab(2'b01);
    for (int k = 1; k < LAT; k++) begin
      hold(1);
      check("lat_E_low", E, 0);
    end
    hold(1);
    check("lat_E_high", E,   1);
    check("lat_U",      U,   1);
    check("lat_Pos",    Pos, 1);
    hold(1);
    check("lat_E_single", E, 0);
    for (int i = 1; i < 20; i++) begin
      set_ab(up_seq[i % 4]);
      hold(4);
    end
    hold(LAT + 2);
    check("up20_pulses", pulses, 20);
    check("up20_U",      U,      1);
    check("up20_Pos",    Pos,    4);

    // 3) down step wraps 0 -> 15, then up back to 0
    do_reset(2'b00);
    set_ab(2'b10);
    hold(LAT + 2);
    check("dn_pulses", pulses, 1);
    check("dn_U",      U,      0);
    check("dn_Pos",    Pos,    15);
    set_ab(2'b00);
    hold(LAT + 2);
    check("upwrap_pulses", pulses, 2);
    check("upwrap_U",      U,      1);
    check("upwrap_Pos",    Pos,    0);

    // 4) illegal 00 -> 11, clear, then clear colliding with a new illegal step
    pulses = 0;
    set_ab(2'b11);
    hold(LAT + 2);
    check("ill_pulses", pulses, 0);
    check("ill_Pos",    Pos,    0);
    check("ill_Err",    Err,    1);
    ErrClr = 1'b1;
    hold(1);
    ErrClr = 1'b0;
    check("clr_Err", Err, 0);
    set_ab(2'b00);
    hold(LAT - 1);
    check("coll_pre_Err", Err, 0);
    ErrClr = 1'b1;
    hold(1);
    ErrClr = 1'b0;
    check("coll_Err", Err, 1);
    check("coll_pulses", pulses, 0);

`ifndef QDEC_FILTER_EN
    // 5) back-to-back steps on consecutive cycles
    do_reset(2'b00);
    set_ab(2'b01);
    hold(1);
    set_ab(2'b11);
    hold(2);
    check("b2b_E1",   E,   1);
    check("b2b_Pos1", Pos, 1);
    hold(1);
    check("b2b_E2",   E,   1);
    check("b2b_Pos2", Pos, 2);
    hold(1);
    check("b2b_E3",   E,   0);
`endif

    // 6) asynchronous reset mid-run with Pos=7 and Err=1
    do_reset(2'b00);
    for (int i = 0; i < 7; i++) begin
      set_ab(up_seq[i % 4]);
      hold(4);
    end
    hold(LAT + 2);
    check("pos7_Pos", Pos, 7);
    set_ab(2'b01);
    hold(LAT + 2);
    check("pos7_Err", Err, 1);
    check("pos7_hold", Pos, 7);
    #2;
    Rst = 1'b0;
    #1;
    check("arst_Pos",   Pos,   0);
    check("arst_E",     E,     0);
    check("arst_U",     U,     0);
    check("arst_Err",   Err,   0);
    check("arst_state", state, ST_INIT);
    hold(2);
    Rst = 1'b1;
    pulses = 0;
    hold(12);
    check("rel_pulses", pulses, 0);
    check("rel_Pos",    Pos,    0);

`ifdef QDEC_FILTER_EN
    // 7) 2-cycle glitch rejected, 4-cycle hold accepted
    do_reset(2'b00);
    set_ab(2'b01);
    hold(2);
    set_ab(2'b00);
    hold(10);
    check("glitch_pulses", pulses, 0);
    check("glitch_Err",    Err,    0);
    set_ab(2'b01);
    hold(4);
    hold(LAT + 2);
    check("filt_pulses", pulses, 1);
    check("filt_U",      U,      1);
    check("filt_Pos",    Pos,    1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
